// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types, constants and helpers for mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef logic [31:0] word_t;

    localparam word_t       c_BASE_ADDR_DEFAULT = 32'h8000_0000;
    localparam int unsigned c_ERR_CNT_W         = 16;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    // Adds 0..2 bad accesses to the error count, clamping at all-ones.
    function automatic logic [c_ERR_CNT_W-1:0] err_sat_add(
        input logic [c_ERR_CNT_W-1:0] cnt,
        input logic [1:0]             inc
    );
        logic [c_ERR_CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(c_ERR_CNT_W-1){1'b0}}, inc};
        return sum[c_ERR_CNT_W] ? {c_ERR_CNT_W{1'b1}} : sum[c_ERR_CNT_W-1:0];
    endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_addr_check.sv
`default_nettype none
// ============================================================================
// Module      : mem_addr_check
// Description : Combinational byte-address window/alignment check and word
//               index extraction for one memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_addr_check
    import mem_pkg::*;
#(
    parameter word_t       BASE_ADDR   = c_BASE_ADDR_DEFAULT,
    parameter int unsigned DEPTH_WORDS = 524288,
    parameter int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  word_t            addr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] index_o
);

    // 33-bit span so a window ending at the top of the address space still fits.
    localparam logic [32:0] c_SPAN = 33'(DEPTH_WORDS) << 2;

    logic [32:0] w_offset;

    always_comb begin
        w_offset = {1'b0, addr_i} - {1'b0, BASE_ADDR};
        valid_o  = (addr_i[1:0] == 2'b00) && (addr_i >= BASE_ADDR) && (w_offset < c_SPAN);
        index_o  = w_offset[IDX_W+1:2];
    end

endmodule : mem_addr_check
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Dual-port (fetch + load/store) word memory with 1-cycle
//               registered reads, address checking and a saturating error
//               counter. Define MEM_CLEAR_EN to zero the array after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_pkg::*;
#(
    parameter word_t       BASE_ADDR   = c_BASE_ADDR_DEFAULT,
    parameter int unsigned DEPTH_WORDS = 524288
) (
    input  logic                   clk,
    input  logic                   reset,
    input  word_t                  instr_addr,
    output word_t                  instr_in,
    input  word_t                  data_addr,
    input  word_t                  data_out,
    input  logic                   data_rd_wr,
    output word_t                  data_in,
    output logic                   mem_ready,
    output logic                   addr_err,
    output logic [c_ERR_CNT_W-1:0] err_count
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    word_t                  mem_q [DEPTH_WORDS];
    state_e                 state_q, state_d;
    word_t                  instr_q, instr_d;
    word_t                  data_q, data_d;
    logic [c_ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                   addr_err_q, addr_err_d;

    logic                   w_ready;
    logic                   w_i_valid, w_d_valid;
    logic [IDX_W-1:0]       w_i_idx, w_d_idx;
    logic [1:0]             w_err_inc;
    logic                   w_wr_en;
    logic [IDX_W-1:0]       w_wr_idx;
    word_t                  w_wr_data;

`ifdef MEM_CLEAR_EN
    localparam logic [IDX_W:0] c_SWEEP_END = (IDX_W+1)'(DEPTH_WORDS);
    logic [IDX_W:0] sweep_q, sweep_d;
`endif

    mem_addr_check #(
        .BASE_ADDR   (BASE_ADDR),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_instr_chk (
        .addr_i  (instr_addr),
        .valid_o (w_i_valid),
        .index_o (w_i_idx)
    );

    mem_addr_check #(
        .BASE_ADDR   (BASE_ADDR),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_data_chk (
        .addr_i  (data_addr),
        .valid_o (w_d_valid),
        .index_o (w_d_idx)
    );

    assign w_ready = (state_q == READY);

    // State sequencing and the single memory write port (sweep or store).
    always_comb begin
        state_d   = state_q;
        w_wr_en   = 1'b0;
        w_wr_idx  = w_d_idx;
        w_wr_data = data_out;
`ifdef MEM_CLEAR_EN
        sweep_d   = sweep_q;
`endif
        case (state_q)
            INIT: begin
`ifdef MEM_CLEAR_EN
                if (sweep_q == c_SWEEP_END) begin
                    state_d = READY;
                end else begin
                    w_wr_en   = 1'b1;
                    w_wr_idx  = sweep_q[IDX_W-1:0];
                    w_wr_data = '0;
                    sweep_d   = sweep_q + (IDX_W+1)'(1);
                end
`else
                state_d = READY;
`endif
            end
            READY: begin
                w_wr_en = (data_rd_wr == 1'b0) && w_d_valid;
            end
            default: state_d = INIT;
        endcase
    end

    // Read data comes from the pre-edge array contents, giving read-first behaviour.
    always_comb begin
        instr_d    = (w_ready && w_i_valid) ? mem_q[w_i_idx] : '0;
        data_d     = (w_ready && w_d_valid) ? mem_q[w_d_idx] : '0;
        w_err_inc  = w_ready ? ({1'b0, ~w_i_valid} + {1'b0, ~w_d_valid}) : 2'd0;
        err_cnt_d  = err_sat_add(err_cnt_q, w_err_inc);
        addr_err_d = addr_err_q | (w_err_inc != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[w_wr_idx] <= w_wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= INIT;
            instr_q    <= '0;
            data_q     <= '0;
            err_cnt_q  <= '0;
            addr_err_q <= 1'b0;
`ifdef MEM_CLEAR_EN
            sweep_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            data_q     <= data_d;
            err_cnt_q  <= err_cnt_d;
            addr_err_q <= addr_err_d;
`ifdef MEM_CLEAR_EN
            sweep_q    <= sweep_d;
`endif
        end
    end

    assign instr_in  = instr_q;
    assign data_in   = data_q;
    assign mem_ready = w_ready;
    assign addr_err  = addr_err_q;
    assign err_count = err_cnt_q;

endmodule : mem_responder
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Directed self-checking bench for mem_responder (DEPTH_WORDS=16),
//               valid with or without MEM_CLEAR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;
    import mem_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam word_t       BASE  = 32'h8000_0000;
`ifdef MEM_CLEAR_EN
    localparam int          EXP_READY_CYC   = 17;
    localparam logic [31:0] EXP_EARLY_READY = 32'd0;
    localparam logic [31:0] EXP_KEPT        = 32'h0000_0000;
`else
    localparam int          EXP_READY_CYC   = 1;
    localparam logic [31:0] EXP_EARLY_READY = 32'd1;
    localparam logic [31:0] EXP_KEPT        = 32'h1234_5678;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    word_t       instr_addr, data_addr, data_out, instr_in, data_in;
    logic        data_rd_wr;
    logic        mem_ready, addr_err;
    logic [15:0] err_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;

    always #5 clk = ~clk;

    mem_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_addr (instr_addr),
        .instr_in   (instr_in),
        .data_addr  (data_addr),
        .data_out   (data_out),
        .data_rd_wr (data_rd_wr),
        .data_in    (data_in),
        .mem_ready  (mem_ready),
        .addr_err   (addr_err),
        .err_count  (err_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            cycles++;
            if (mem_ready) break;
        end
    endtask

    task automatic drive(input word_t ia, input word_t da, input word_t dw, input logic rw);
        instr_addr = ia;
        data_addr  = da;
        data_out   = dw;
        data_rd_wr = rw;
    endtask

    initial begin
        drive(BASE, BASE, 32'h0, 1'b1);
        #1 reset = 1'b1;
        #2;
        check("rst_instr_in",  instr_in, 32'h0);
        check("rst_data_in",   data_in, 32'h0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        check("rst_addr_err",  32'(addr_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        repeat (3) tick();

        // Release, then hit reset again once the sweep has reached index 5.
        reset = 1'b0;
        repeat (5) tick();
        check("early_ready", 32'(mem_ready), EXP_EARLY_READY);
        reset = 1'b1;
        #1;
        check("midsweep_rst_ready", 32'(mem_ready), 32'd0);
        check("midsweep_rst_data",  data_in, 32'h0);
        #1 reset = 1'b0;

        // Invalid addresses while not ready must not be counted.
        drive(32'h7FFF_FFFC, 32'h8000_0002, 32'h0, 1'b1);
        wait_ready(cyc);
        drive(BASE, BASE, 32'h0, 1'b1);
        check("ready_cycle", 32'(cyc), 32'(EXP_READY_CYC));
        check("init_no_errs", 32'(err_count), 32'd0);

`ifdef MEM_CLEAR_EN
        for (int i = 0; i < 16; i++) begin
            drive(BASE + 32'(4 * (15 - i)), BASE + 32'(4 * i), 32'h0, 1'b1);
            tick();
            check($sformatf("clear_d%0d", i), data_in, 32'h0);
            check($sformatf("clear_i%0d", 15 - i), instr_in, 32'h0);
        end
        check("clear_no_errs", 32'(err_count), 32'd0);
`endif

        drive(BASE, 32'h8000_0004, 32'h0BAD_F00D, 1'b0); tick();
        drive(BASE, 32'h8000_0000, 32'h1111_1111, 1'b0); tick();
        drive(BASE, 32'h8000_003C, 32'hCAFE_0001, 1'b0); tick();
        drive(BASE, 32'h8000_0008, 32'h1234_5678, 1'b0); tick();
        drive(BASE, 32'h8000_0008, 32'h0,         1'b1); tick();
        check("wr_rd_0x08", data_in, 32'h1234_5678);

        // Same-cycle write and fetch of one word: both ports see the old value.
        drive(32'h8000_0004, 32'h8000_0004, 32'hAAAA_5555, 1'b0); tick();
        check("rf_instr_old", instr_in, 32'h0BAD_F00D);
        check("rf_data_old",  data_in, 32'h0BAD_F00D);
        drive(32'h8000_0004, 32'h8000_0000, 32'h0, 1'b1); tick();
        check("rf_instr_new", instr_in, 32'hAAAA_5555);
        check("rd_0x00",      data_in, 32'h1111_1111);

        drive(32'h7FFF_FFFC, 32'h8000_0002, 32'hDEAD_BEEF, 1'b0); tick();
        check("bad_addr_err",  32'(addr_err), 32'd1);
        check("bad_err_cnt2",  32'(err_count), 32'd2);
        check("bad_instr_in",  instr_in, 32'h0);
        check("bad_data_in",   data_in, 32'h0);
        drive(32'h8000_0004, 32'h8000_0000, 32'h0, 1'b1); tick();
        check("bad_wr_dropped", data_in, 32'h1111_1111);
        check("bad_instr_ok",   instr_in, 32'hAAAA_5555);
        check("bad_cnt_hold",   32'(err_count), 32'd2);

        // Last valid word on fetch, first word past the end on data.
        drive(32'h8000_003C, 32'h8000_0040, 32'h0, 1'b1); tick();
        check("top_instr",   instr_in, 32'hCAFE_0001);
        check("top_oob_rd",  data_in, 32'h0);
        check("top_err_cnt", 32'(err_count), 32'd3);

        drive(32'h0000_0000, 32'h0000_0001, 32'h0, 1'b1);
        repeat (100) tick();
        check("sat_mid", 32'(err_count), 32'd203);
        for (int i = 0; i < 32900; i++) tick();
        check("sat_full", 32'(err_count), 32'h0000_FFFF);
        tick();
        check("sat_hold", 32'(err_count), 32'h0000_FFFF);
        check("sat_sticky", 32'(addr_err), 32'd1);

        // Reset while READY with non-zero outputs: asynchronous clear.
        drive(32'h8000_003C, 32'h8000_0008, 32'h0, 1'b1); tick();
        check("pre_rst_rd", data_in, 32'h1234_5678);
        reset = 1'b1;
        #1;
        check("rdy_rst_data",  data_in, 32'h0);
        check("rdy_rst_instr", instr_in, 32'h0);
        check("rdy_rst_cnt",   32'(err_count), 32'd0);
        check("rdy_rst_err",   32'(addr_err), 32'd0);
        check("rdy_rst_ready", 32'(mem_ready), 32'd0);
        #1 reset = 1'b0;
        wait_ready(cyc);
        check("ready_cycle2", 32'(cyc), 32'(EXP_READY_CYC));
        tick();
        check("post_rst_rd", data_in, EXP_KEPT);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mem_responder
`default_nettype wire
